bitstream_loader: RTL

//  Master end of the configuration scan chain. Accepts configuration bytes from a host

---
 rtl/bitstream_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bitstream_loader.sv
// Configuration scan-chain master: accepts host bytes over valid/ready and shifts exactly
// CHAIN_LEN bits LSB-first into the fabric chain, capturing the chain tail as readback bytes.
module bitstream_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_prog_clk,
  output logic       o_prog_en,
  output logic       o_prog_in,
  input  logic       i_prog_out
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOW, S_HIGH, S_FINISH} state_t;

  state_t        r_state, w_state_nx;
  logic [BW-1:0] r_bits;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bidx, r_rbcnt;
  logic [7:0]    r_byte, r_rb;
  logic          w_div_end, w_take, w_rise, w_next_bit;
  logic [2:0]    w_bidx_nx;
  logic [7:0]    w_rb_nx;

  assign w_div_end  = (r_div == DW'(CLK_DIV - 1));
  assign w_take     = (r_state == S_FETCH) && i_s_valid;
  assign w_rise     = (r_state == S_LOW) && w_div_end;
  assign w_next_bit = (r_state == S_HIGH) && w_div_end && (w_state_nx == S_LOW);
  assign w_bidx_nx  = r_bidx + 3'd1;
  // readback bits land at their final position so a short last byte comes out zero-padded
  assign w_rb_nx    = r_rb | (8'(i_prog_out) << r_rbcnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nx = S_FETCH;
      S_FETCH:  if (i_s_valid) w_state_nx = S_LOW;
      S_LOW:    if (w_div_end) w_state_nx = S_HIGH;
      S_HIGH: begin
        if (w_div_end) begin
          if (r_bits == '0)        w_state_nx = S_FINISH;
          else if (r_bidx == 3'd7) w_state_nx = S_FETCH;
          else                     w_state_nx = S_LOW;
        end
      end
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Chain pins are registered from the next state so they never glitch on state decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_s_ready  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
      o_prog_clk <= 1'b0;
      o_prog_en  <= 1'b0;
      o_prog_in  <= 1'b0;
      r_bits     <= '0;
      r_div      <= '0;
      r_bidx     <= '0;
      r_rbcnt    <= '0;
      r_byte     <= '0;
      r_rb       <= '0;
    end else begin
      o_rd_valid <= 1'b0;
      o_s_ready  <= (w_state_nx == S_FETCH);
      o_prog_en  <= (w_state_nx != S_IDLE);
      o_prog_clk <= (w_state_nx == S_HIGH);
      r_div      <= (w_state_nx != r_state) ? '0 : r_div + DW'(1);

      if (r_state == S_IDLE && i_start) begin
        o_busy  <= 1'b1;
        o_done  <= 1'b0;
        r_bits  <= BW'(CHAIN_LEN);
        r_rb    <= '0;
        r_rbcnt <= '0;
      end

      if (w_take) begin
        r_byte    <= i_s_data;
        r_bidx    <= '0;
        o_prog_in <= i_s_data[0];
      end

      // prog_out is sampled here, before the chain sees the prog_clk rise
      if (w_rise) begin
        r_bits <= r_bits - BW'(1);
        if (r_rbcnt == 3'd7 || r_bits == BW'(1)) begin
          o_rd_data  <= w_rb_nx;
          o_rd_valid <= 1'b1;
          r_rb       <= '0;
          r_rbcnt    <= '0;
        end else begin
          r_rb    <= w_rb_nx;
          r_rbcnt <= r_rbcnt + 3'd1;
        end
      end

      if (w_next_bit) begin
        r_bidx    <= w_bidx_nx;
        o_prog_in <= r_byte[w_bidx_nx];
      end

      if (r_state == S_FINISH) begin
        o_busy    <= 1'b0;
        o_done    <= 1'b1;
        o_prog_in <= 1'b0;
      end
    end
  end
endmodule
